// File: rtl/cpu_types_pkg.sv
// Shared scoreboard types and configuration for the hazard/forwarding controller.
// The scoreboard geometry (NREGS, NSTAGES, NFLUSH) lives here so every user agrees on widths.
package cpu_types_pkg;

  localparam int NREGS   = 32;
  localparam int NSTAGES = 3;
  localparam int NFLUSH  = 2;
  localparam int RW      = $clog2(NREGS);
  localparam int SW      = $clog2(NSTAGES + 1);

  typedef logic [RW-1:0] regbits_t;
  typedef logic [SW-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REGFILE = '0;

  typedef struct packed {
    logic     valid;
    regbits_t rd;
    fwd_sel_t avail;
  } sb_entry_t;

  // Entry 0 takes this when decode is stalled or squashed.
  function automatic sb_entry_t sb_bubble();
    return '0;
  endfunction

endpackage

// File: rtl/sb_match.sv
// One source operand against the whole scoreboard: youngest matching writer
// selects the forward path, or raises not_ready_o if its result is not out yet.
module sb_match
  import cpu_types_pkg::*;
(
  input  logic [RW-1:0] rs_i,
  input  logic          use_i,
  input  sb_entry_t     sb_i [NSTAGES],
  output logic [SW-1:0] fwd_o,
  output logic          not_ready_o
);

  logic found;

  always_comb begin
    fwd_o       = FWD_REGFILE;
    not_ready_o = 1'b0;
    found       = 1'b0;
    for (int i = 0; i < NSTAGES; i++) begin
      if (!found && use_i && (rs_i != '0) && sb_i[i].valid && (sb_i[i].rd == rs_i)) begin
        found = 1'b1;
        // Stage i output carries the result once i has reached the producer's avail stage.
        if (i >= int'(sb_i[i].avail)) begin
          fwd_o = fwd_sel_t'(i + 1);
        end else begin
          not_ready_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: shift scoreboard of in-flight writers past decode,
// per-source forward selects and load-use stall. Optional HAZARD_PERF_EN adds stall/flush counters.
module hazard_scoreboard
  import cpu_types_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               adv_i,
  input  logic               freeze_i,
  input  logic               flush_i,
  input  logic               id_valid_i,
  input  logic [RW-1:0]      id_rs1_i,
  input  logic               id_use1_i,
  input  logic [RW-1:0]      id_rs2_i,
  input  logic               id_use2_i,
  input  logic [RW-1:0]      id_rd_i,
  input  logic               id_regwr_i,
  input  logic [SW-1:0]      id_avail_i,
  output logic               stall_o,
  output logic [SW-1:0]      fwd1_o,
  output logic [SW-1:0]      fwd2_o,
`ifdef HAZARD_PERF_EN
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o,
`endif
  output logic [NSTAGES-1:0] inflight_o
);

  // Handshake: the scoreboard advances only on cycles with adv_i=1 and freeze_i=0;
  // stall_o is combinational from current state and decode inputs and is valid every cycle.

  sb_entry_t sb_q [NSTAGES];
  sb_entry_t sb_d [NSTAGES];
  logic      update;
  logic      nr1, nr2;

  sb_match u_match1 (
    .rs_i        (id_rs1_i),
    .use_i       (id_use1_i),
    .sb_i        (sb_q),
    .fwd_o       (fwd1_o),
    .not_ready_o (nr1)
  );

  sb_match u_match2 (
    .rs_i        (id_rs2_i),
    .use_i       (id_use2_i),
    .sb_i        (sb_q),
    .fwd_o       (fwd2_o),
    .not_ready_o (nr2)
  );

  assign stall_o = nr1 | nr2;
  assign update  = adv_i & ~freeze_i;

  always_comb begin
    for (int i = 0; i < NSTAGES; i++) begin
      inflight_o[i] = sb_q[i].valid;
    end
  end

  always_comb begin
    sb_d = sb_q;
    if (update) begin
      for (int i = NSTAGES - 1; i > 0; i--) begin
        sb_d[i] = sb_q[i-1];
      end
      if (stall_o) begin
        sb_d[0] = sb_bubble();
      end else begin
        sb_d[0].valid = id_valid_i & id_regwr_i & (id_rd_i != '0);
        sb_d[0].rd    = id_rd_i;
        sb_d[0].avail = id_avail_i;
      end
      // Squash applies to the post-shift view, so it also wins over a stall bubble.
      if (flush_i) begin
        for (int i = 0; i < NFLUSH; i++) begin
          sb_d[i] = sb_bubble();
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NSTAGES; i++) begin
        sb_q[i] <= sb_bubble();
      end
    end else begin
      for (int i = 0; i < NSTAGES; i++) begin
        sb_q[i] <= sb_d[i];
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (update && stall_o && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (update && flush_i && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
